// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI bridge: FSM state encoding,
// fixed AXI burst fields and default transaction IDs.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } bridge_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE  = 4'd0;
  localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

  // Size code 3 has no meaning on the SRAM side; it is carried as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? 2'd2 : size;
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3-style single-beat master bus between the bridge (master) and the
// downstream interconnect (slave).
interface sram_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits; write data is
// already lane-aligned by the core so only the strobe needs deriving.
module sram_axi_bridge_wstrb_gen (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  // Lane select per access size; unknown sizes fall back to a full word.
  always_comb begin
    wstrb = 4'b1111;
    case (size)
      2'd0:    wstrb = 4'b0001 << addr_lo;
      2'd1:    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Merges the core's instruction and data SRAM-like ports onto one AXI master,
// one transaction in flight, data port winning simultaneous requests.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
  parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  sram_axi_bridge_if.master axi
);

  bridge_state_t state_r, state_n;

  logic        owner_data_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic [31:0] inst_rdata_r;
  logic [31:0] data_rdata_r;

  logic        in_idle_s;
  logic        accept_s;
  logic        sel_wr_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_wstrb_s;
  logic        unused_inputs_s;

  // rst gates acceptance so nothing leaves the bridge while it is held in reset.
  assign in_idle_s    = (state_r == ST_IDLE) & ~rst;
  assign data_addr_ok = in_idle_s & data_req;
  assign inst_addr_ok = in_idle_s & inst_req & ~data_req;
  assign accept_s     = data_addr_ok | inst_addr_ok;

  assign sel_wr_s    = data_req ? data_wr : 1'b0;
  assign sel_size_s  = norm_size(data_req ? data_size : inst_size);
  assign sel_addr_s  = data_req ? data_addr : inst_addr;
  assign sel_wdata_s = data_wdata;

  sram_axi_bridge_wstrb_gen u_wstrb_gen (
    .size    (sel_size_s),
    .addr_lo (sel_addr_s[1:0]),
    .wstrb   (sel_wstrb_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; the write-address state waits for both AW and W handshakes.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n = sel_wr_s ? ST_WR_ADDR : ST_RD_ADDR;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (axi.arready) state_n = ST_RD_DATA;
        else             state_n = ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        if (axi.rvalid) state_n = ST_RESP;
        else            state_n = ST_RD_DATA;
      end
      ST_WR_ADDR: begin
        if ((aw_done_r | axi.awready) & (w_done_r | axi.wready)) state_n = ST_WR_RESP;
        else                                                     state_n = ST_WR_ADDR;
      end
      ST_WR_RESP: begin
        if (axi.bvalid) state_n = ST_RESP;
        else            state_n = ST_WR_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Request capture, write-channel progress flags and read-data latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_data_r <= 1'b0;
      size_r       <= 2'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      wstrb_r      <= 4'd0;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      inst_rdata_r <= 32'd0;
      data_rdata_r <= 32'd0;
    end else begin
      if (accept_s) begin
        owner_data_r <= data_req;
        size_r       <= sel_size_s;
        addr_r       <= sel_addr_s;
        wdata_r      <= sel_wdata_s;
        wstrb_r      <= sel_wstrb_s;
      end
      if ((state_r != ST_WR_ADDR) || (state_n != ST_WR_ADDR)) begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else begin
        if (axi.awready) aw_done_r <= 1'b1;
        if (axi.wready)  w_done_r  <= 1'b1;
      end
      if ((state_r == ST_RD_DATA) && axi.rvalid) begin
        if (owner_data_r) data_rdata_r <= axi.rdata;
        else              inst_rdata_r <= axi.rdata;
      end
    end
  end

  assign axi.arid    = owner_data_r ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_r;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = {1'b0, size_r};
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state_r == ST_RD_ADDR);
  assign axi.rready  = (state_r == ST_RD_DATA);

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_r;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = {1'b0, size_r};
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = (state_r == ST_WR_ADDR) & ~aw_done_r;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_r;
  assign axi.wstrb   = wstrb_r;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state_r == ST_WR_ADDR) & ~w_done_r;
  assign axi.bready  = (state_r == ST_WR_RESP);

  assign inst_data_ok = (state_r == ST_RESP) & ~owner_data_r;
  assign data_data_ok = (state_r == ST_RESP) &  owner_data_r;
  assign inst_rdata   = inst_rdata_r;
  assign data_rdata   = data_rdata_r;

  // Fields the bridge deliberately does not look at.
  assign unused_inputs_s = ^{inst_wr, inst_wdata, axi.rid, axi.rresp, axi.rlast,
                             axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized bench: a cycle-indexed AXI slave plus a timing/behaviour model of
// each transaction derived from the bridge's documented latency rules.
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;

  sram_axi_bridge_if bus ();

  sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .axi(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_inst_rdata = 32'd0;
  logic [31:0] exp_data_rdata = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe covers 2**size bytes on the naturally aligned lane group containing addr.
  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    int base;
    nb   = (size == 2'd3) ? 4 : (1 << size);
    base = int'(addr[1:0]) & ~(nb - 1);
    return 4'(((1 << nb) - 1) << base);
  endfunction

  function automatic logic [6:0] out_vec();
    return {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
            inst_data_ok, data_data_ok};
  endfunction

  task automatic slave_idle();
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rid = 4'd0;
    bus.rresp = 2'd0; bus.rlast = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bid = 4'd0; bus.bresp = 2'd0;
  endtask

  // One complete transaction, cycle k=0 being the addr_ok cycle.
  task automatic do_txn(input bit is_d, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int d1, input int d2, input int d3,
                        input bit hold_other, input int abort_k);
    bit is_write;
    logic [2:0] exp_size;
    logic [3:0] exp_id;
    int k_ar, k_r, k_aw, k_w, k_b0, k_bh, k_done;
    logic [6:0] exp_vec;
    is_write = is_d & wr;
    exp_size = (size == 2'd3) ? 3'd2 : {1'b0, size};
    exp_id   = is_d ? 4'd1 : 4'd0;
    k_ar = 1 + d1;
    k_r  = k_ar + 1 + d2;
    k_aw = 1 + d1;
    k_w  = 1 + d2;
    k_b0 = ((k_aw > k_w) ? k_aw : k_w) + 1;
    k_bh = k_b0 + d3;
    k_done = is_write ? (k_bh + 1) : (k_r + 1);

    @(negedge clk);
    if (is_d) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
      inst_req = hold_other;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
      data_req = 1'b0;
    end
    #1;
    check_val("addr_ok_data", {31'd0, data_addr_ok}, {31'd0, is_d});
    check_val("addr_ok_inst", {31'd0, inst_addr_ok}, {31'd0, !is_d});

    for (int k = 1; k <= k_done; k++) begin
      @(negedge clk);
      // Requests toggle freely mid-transaction; none may be accepted.
      if (is_d) begin
        data_req = 1'($urandom_range(0, 1)); data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom_range(0, 1));
        inst_req = hold_other ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        inst_req = 1'($urandom_range(0, 1)); inst_addr = $urandom;
        data_req = 1'($urandom_range(0, 1));
      end
      bus.arready = !is_write && (k >= k_ar);
      bus.rvalid  = !is_write && (k == k_r);
      bus.rdata   = (k == k_r) ? rd : $urandom;
      bus.rid     = 4'($urandom);
      bus.rresp   = 2'($urandom);
      bus.awready = is_write && (k >= k_aw);
      bus.wready  = is_write && (k >= k_w);
      bus.bvalid  = is_write && (k == k_bh);
      bus.bresp   = 2'($urandom);
      if (k == abort_k) begin
        inst_req = 1'b1; data_req = 1'b1;
        rst = 1'b1;
        #1;
        check_val("rst_outputs", {25'd0, out_vec()}, 32'd0);
        check_val("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check_val("rst_inst_rdata", inst_rdata, 32'd0);
        check_val("rst_data_rdata", data_rdata, 32'd0);
        exp_inst_rdata = 32'd0;
        exp_data_rdata = 32'd0;
        inst_req = 1'b0; data_req = 1'b0;
        slave_idle();
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      #1;
      exp_vec = {!is_write && (k <= k_ar),
                 !is_write && (k > k_ar) && (k <= k_r),
                 is_write && (k <= k_aw),
                 is_write && (k <= k_w),
                 is_write && (k >= k_b0) && (k <= k_bh),
                 !is_d && (k == k_done),
                 is_d && (k == k_done)};
      check_val("handshakes", {25'd0, out_vec()}, {25'd0, exp_vec});
      check_val("busy_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      if (!is_write && k == k_ar) begin
        check_val("arid", {28'd0, bus.arid}, {28'd0, exp_id});
        check_val("araddr", bus.araddr, addr);
        check_val("arsize", {29'd0, bus.arsize}, {29'd0, exp_size});
      end
      if (is_write && k == k_aw) begin
        check_val("awid", {28'd0, bus.awid}, 32'd1);
        check_val("awaddr", bus.awaddr, addr);
        check_val("awsize", {29'd0, bus.awsize}, {29'd0, exp_size});
      end
      if (is_write && k == k_w) begin
        check_val("wdata", bus.wdata, wdata);
        check_val("wstrb", {28'd0, bus.wstrb}, {28'd0, model_strb(size, addr)});
        check_val("wlast", {31'd0, bus.wlast}, 32'd1);
      end
      if (k == k_done) begin
        if (!is_write) begin
          if (is_d) exp_data_rdata = rd;
          else      exp_inst_rdata = rd;
        end
        check_val("inst_rdata", inst_rdata, exp_inst_rdata);
        check_val("data_rdata", data_rdata, exp_data_rdata);
      end
    end
    slave_idle();
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    slave_idle();
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_outputs", {25'd0, out_vec()}, 32'd0);
    check_val("reset_inst_rdata", inst_rdata, 32'd0);
    check_val("reset_data_rdata", data_rdata, 32'd0);
    check_val("const_len_burst", {bus.arlen, bus.awlen, 6'd0, bus.arburst, bus.awburst, 12'd0},
              {4'd0, 4'd0, 6'd0, 2'b01, 2'b01, 12'd0});
    check_val("const_wid", {28'd0, bus.wid}, 32'd1);
    rst = 1'b0;

    do_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0, 32'h3C1D_0001, 0, 0, 0, 1'b0, -1);
    inst_addr = 32'hBFC0_0004;
    do_txn(1'b1, 1'b0, 2'd2, 32'h8000_1004, 32'd0, 32'h1234_5678, 0, 0, 0, 1'b1, -1);
    do_txn(1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 32'd0, 32'h2408_0002, 0, 0, 0, 1'b0, -1);
    do_txn(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 32'd0, 0, 0, 0, 1'b0, -1);
    do_txn(1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'd0, 3, 0, 0, 1'b0, -1);
    do_txn(1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'h5566_0000, 32'd0, 0, 0, 5, 1'b0, -1);
    do_txn(1'b1, 1'b0, 2'd2, 32'h8000_0020, 32'd0, 32'hCAFE_F00D, 0, 4, 0, 1'b0, 3);
    do_txn(1'b1, 1'b0, 2'd2, 32'h8000_0024, 32'd0, 32'h0BAD_CAFE, 0, 0, 0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net in case the DUT or bench ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
